// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control unit:
// opcodes, FSM state codes and datapath mux/ALU select codes.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_IWB    = 4'd11
    } state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // BNE and ADDI only exist when the extension set is enabled.
    function automatic logic op_legal(input logic [5:0] op, input logic en_ext);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
            OP_BNE, OP_ADDI:                  return en_ext;
            default:                          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Moore output decoder: registered state (plus op / mem_ready gating)
// to every datapath enable and mux select.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
#(
    parameter bit EN_EXT = 1'b1
) (
    input  logic       active_i,
    input  state_e     state_i,
    input  logic [5:0] op_i,
    input  logic       mem_ready_i,
    output logic       pc_write_o,
    output logic       pc_write_cond_o,
    output logic       branch_ne_o,
    output logic       i_or_d_o,
    output logic       mem_read_o,
    output logic       mem_write_o,
    output logic       ir_write_o,
    output logic       reg_write_o,
    output logic       reg_dst_o,
    output logic       mem_to_reg_o,
    output logic       alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic [1:0] pc_source_o,
    output logic       illegal_o
);

    always_comb begin
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        branch_ne_o     = 1'b0;
        i_or_d_o        = 1'b0;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        ir_write_o      = 1'b0;
        reg_write_o     = 1'b0;
        reg_dst_o       = 1'b0;
        mem_to_reg_o    = 1'b0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = SRCB_B;
        alu_op_o        = ALUOP_ADD;
        pc_source_o     = PCSRC_ALU;
        illegal_o       = 1'b0;
        // active_i low (reset held) forces every strobe off, FETCH included.
        if (active_i) begin
            case (state_i)
                S_FETCH: begin
                    mem_read_o  = 1'b1;
                    alu_src_b_o = SRCB_4;
                    ir_write_o  = mem_ready_i;
                    pc_write_o  = mem_ready_i;
                end
                S_DECODE: begin
                    alu_src_b_o = SRCB_IMMSH;
                    illegal_o   = !op_legal(op_i, EN_EXT);
                end
                S_MEMADR, S_ADDIEX: begin
                    alu_src_a_o = 1'b1;
                    alu_src_b_o = SRCB_IMM;
                end
                S_MEMRD: begin
                    mem_read_o = 1'b1;
                    i_or_d_o   = 1'b1;
                end
                S_MEMWB: begin
                    reg_write_o  = 1'b1;
                    mem_to_reg_o = 1'b1;
                end
                S_MEMWR: begin
                    mem_write_o = 1'b1;
                    i_or_d_o    = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a_o = 1'b1;
                    alu_op_o    = ALUOP_FUNCT;
                end
                S_RWB: begin
                    reg_write_o = 1'b1;
                    reg_dst_o   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a_o     = 1'b1;
                    alu_op_o        = ALUOP_SUB;
                    pc_write_cond_o = 1'b1;
                    pc_source_o     = PCSRC_ALUOUT;
                    branch_ne_o     = (op_i == OP_BNE);
                end
                S_JUMP: begin
                    pc_write_o  = 1'b1;
                    pc_source_o = PCSRC_JUMP;
                end
                S_IWB: begin
                    reg_write_o = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multicycle MIPS main control unit: state register, next-state logic,
// retired-instruction counter; outputs decoded in mc_ctrl_outdec.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter bit          WAIT_MEM = 1'b1,
    parameter bit          EN_EXT   = 1'b1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             BranchNe,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       PCSource,
    output logic             illegal,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               mem_rdy;

    assign mem_rdy = WAIT_MEM ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH;
                if (op_legal(op, EN_EXT)) begin
                    case (op)
                        OP_LW, OP_SW:    state_d = S_MEMADR;
                        OP_R:            state_d = S_EXEC;
                        OP_BEQ, OP_BNE:  state_d = S_BRANCH;
                        OP_J:            state_d = S_JUMP;
                        OP_ADDI:         state_d = S_ADDIEX;
                        default:         state_d = S_FETCH;
                    endcase
                end
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_IWB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    assign cnt_d = (state_q == S_FETCH && mem_rdy) ? cnt_q + CNT_W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    mc_ctrl_outdec #(
        .EN_EXT(EN_EXT)
    ) u_outdec (
        .active_i        (!rst),
        .state_i         (state_q),
        .op_i            (op),
        .mem_ready_i     (mem_rdy),
        .pc_write_o      (PCWrite),
        .pc_write_cond_o (PCWriteCond),
        .branch_ne_o     (BranchNe),
        .i_or_d_o        (IorD),
        .mem_read_o      (MemRead),
        .mem_write_o     (MemWrite),
        .ir_write_o      (IRWrite),
        .reg_write_o     (RegWrite),
        .reg_dst_o       (RegDst),
        .mem_to_reg_o    (MemtoReg),
        .alu_src_a_o     (ALUSrcA),
        .alu_src_b_o     (ALUSrcB),
        .alu_op_o        (ALUOp),
        .pc_source_o     (PCSource),
        .illegal_o       (illegal)
    );

    assign state     = state_q;
    assign instr_cnt = cnt_q;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle MIPS main control unit: a Moore state machine that sequences fetch, decode, execute, memory and write-back over several cycles for each instruction. It sits beside the multicycle datapath (PC, IR, MDR, A/B, ALUOut registers), reads the opcode from the IR, and drives every datapath enable and mux select. It extends the single-cycle opcode set with BNE and ADDI, and adds an optional memory-ready stall handshake, an illegal-opcode flag and a retired-instruction counter.

## Interface
- `WAIT_MEM`, 1: 1 = FETCH/MEMRD/MEMWR stall until `mem_ready`; 0 = `mem_ready` ignored (treated as 1)
- `EN_EXT`, 1: 1 = BNE and ADDI decoded; 0 = both treated as illegal
- `CNT_W`, 16: width of `instr_cnt`
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `op` in 6: IR[31:26]; stable from DECODE until next FETCH
- `mem_ready` in 1: memory completes the current access this cycle
- `PCWrite` out 1: unconditional PC load
- `PCWriteCond` out 1: PC load if branch condition holds
- `BranchNe` out 1: branch condition is `!zero` (else `zero`)
- `IorD` out 1: memory address 0 = PC, 1 = ALUOut
- `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `RegDst`, `MemtoReg`, `ALUSrcA` out 1 each
- `ALUSrcB` out 2: 00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
- `ALUOp` out 2: 00 add, 01 sub, 10 funct
- `PCSource` out 2: 00 ALU result, 01 ALUOut, 10 jump target
- `illegal` out 1: high in the DECODE cycle of an unsupported opcode
- `state` out 4: current state encoding, debug only
- `instr_cnt` out CNT_W: instructions fetched since reset

## Operation
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BRANCH 8, JUMP 9, ADDIEX 10, IWB 11. Outputs not listed for a state are 0.
- FETCH: MemRead=1, ALUSrcB=01. IRWrite and PCWrite are high only when `mem_ready`. Go to DECODE on `mem_ready`, else stay.
- DECODE: ALUSrcB=11. Next state by `op`:
  - LW 100011 / SW 101011 -> MEMADR
  - R 000000 -> EXEC
  - BEQ 000100 -> BRANCH
  - BNE 000101 -> BRANCH, only if EN_EXT
  - J 000010 -> JUMP
  - ADDI 001000 -> ADDIEX, only if EN_EXT
  - any other opcode -> FETCH with `illegal`=1 (instruction dropped, no write)
- MEMADR: ALUSrcA=1, ALUSrcB=10. Next MEMRD for LW, MEMWR for SW.
- MEMRD: MemRead=1, IorD=1. Go to MEMWB on `mem_ready`.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. Next FETCH.
- MEMWR: MemWrite=1, IorD=1, held until `mem_ready`, then FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegWrite=1, RegDst=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01, BranchNe=(op==BNE). Next FETCH.
- JUMP: PCWrite=1, PCSource=10. Next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10. Next IWB.
- IWB: RegWrite=1, RegDst=0, MemtoReg=0. Next FETCH.
- `instr_cnt` increments on each FETCH->DECODE transition and wraps from 2^CNT_W-1 to 0.

## Timing
- Cycles per instruction with `mem_ready` held at 1: LW 5, SW 4, R 4, ADDI 4, BEQ/BNE 3, J 3, illegal 2. Each stalled cycle adds 1.
- Outputs are a pure function of the registered state plus `op`/`mem_ready` gating; there is no combinational path from `op` to write strobes outside the DECODE/BRANCH/MEMADR states.
- While `rst` is high: state=FETCH, every output=0 (including FETCH strobes), `instr_cnt`=0. In the first cycle after release, FETCH outputs apply.
- Reset mid-instruction: abandon immediately; no RegWrite/MemWrite/PCWrite may occur after `rst` rises.
- WAIT_MEM=0: stalls are impossible, and `mem_ready` toggling has no effect.

## Structure
- Package `mc_ctrl_pkg` holds:
  - opcode constants (R, LW, SW, BEQ, BNE, J, ADDI)
  - 4-bit state encodings
  - ALUOp, ALUSrcB and PCSource codes
- One sub-module, `mc_ctrl_outdec`: combinational state/op/mem_ready -> control outputs. The top keeps the state register, next-state logic and counter.

## Test plan
- Reset, then LW with `mem_ready`=1 -> states 0,1,2,3,4,0; MemtoReg=RegWrite=1 only in state 4; `instr_cnt`=1.
- SW with `mem_ready` low for 3 cycles in MEMWR -> MemWrite high for 4 cycles, IorD=1, then FETCH; total 7 cycles.
- BNE with EN_EXT=1 -> BRANCH with BranchNe=1, PCWriteCond=1, PCSource=01. Same opcode with EN_EXT=0 -> `illegal`=1 in DECODE, return to FETCH, no strobe.
- Opcode 111111 -> `illegal` pulse of one cycle, 2-cycle instruction, RegWrite/MemWrite/PCWriteCond never high.
- `rst` asserted in MEMWB -> RegWrite drops the same cycle, state=0, `instr_cnt`=0. After release, FETCH MemRead=1.
- CNT_W=2, 5 consecutive J instructions -> `instr_cnt` sequence 1,2,3,0,1; each J is 3 cycles with PCSource=10.
